// File: rtl/video_frame_source.sv
// video_frame_source
// Reads one NUM_LINES x LINE_WIDTH frame from a frame-buffer read port in raster
// order and replays it as a valid/data/eol stream with sof/eof markers and
// HBLANK idle cycles between lines. A small prefetch FIFO with credit-limited
// requests hides the variable read latency of the memory.
module video_frame_source #(
    parameter  int DATA_WIDTH = 8,
    parameter  int LINE_WIDTH = 640,
    parameter  int NUM_LINES  = 480,
    parameter  int HBLANK     = 16,
    parameter  int FIFO_DEPTH = 8,
    localparam int ADDR_WIDTH = $clog2(LINE_WIDTH * NUM_LINES)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    input  logic                  i_rd_valid,
    input  logic [DATA_WIDTH-1:0] i_rd_data,
    output logic                  o_valid_out,
    output logic [DATA_WIDTH-1:0] o_data_out,
    output logic                  o_eol_out,
    output logic                  o_sof_out,
    output logic                  o_eof_out
);

    localparam int TOTAL   = LINE_WIDTH * NUM_LINES;
    localparam int FETCH_W = $clog2(TOTAL + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int SUM_W   = CNT_W + 1;
    localparam int COL_W   = $clog2(LINE_WIDTH);
    localparam int LINE_W  = $clog2(NUM_LINES + 1);
    localparam int HB_W    = $clog2(HBLANK + 2);

    localparam logic [FETCH_W-1:0] TOTAL_F   = FETCH_W'(TOTAL);
    localparam logic [SUM_W-1:0]   DEPTH_S   = SUM_W'(FIFO_DEPTH);
    localparam logic [COL_W-1:0]   LAST_COL  = COL_W'(LINE_WIDTH - 1);
    localparam logic [LINE_W-1:0]  LAST_LINE = LINE_W'(NUM_LINES - 1);
    localparam logic [HB_W-1:0]    HB_LAST   = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t                 state;
    logic [FETCH_W-1:0]     fetch_cnt;
    logic [CNT_W-1:0]       outstanding;
    logic [CNT_W-1:0]       fifo_count;
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [DATA_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
    logic [COL_W-1:0]       col;
    logic [LINE_W-1:0]      line;
    logic [HB_W-1:0]        hb_cnt;
    logic                   credit_ok;
    logic                   accept_rd;
    logic                   pop;

    // A request may only be issued when a FIFO slot is guaranteed for its response,
    // so in-flight reads plus buffered pixels never exceed the FIFO capacity.
    assign credit_ok = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_S;
    assign o_rd_en   = o_busy && (fetch_cnt < TOTAL_F) && credit_ok;
    assign o_rd_addr = fetch_cnt[ADDR_WIDTH-1:0];
    assign accept_rd = i_rd_valid && (outstanding != '0);
    assign pop       = (state == S_ACTIVE) && (fifo_count != '0);

    // Fetch address and count of read requests still awaiting a response
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            fetch_cnt   <= '0;
            outstanding <= '0;
        end else begin
            if (state == S_DONE) begin
                fetch_cnt <= '0;
            end else if (o_rd_en) begin
                fetch_cnt <= fetch_cnt + FETCH_W'(1);
            end
            case ({o_rd_en, accept_rd})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Prefetch FIFO storage, written only by accepted read responses
    always_ff @(posedge i_clk) begin
        if (accept_rd) begin
            fifo_mem[wr_ptr] <= i_rd_data;
        end
    end

    // Prefetch FIFO pointers and occupancy
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (accept_rd) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({accept_rd, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame sequencer: pops pixels into the registered output stream and paces lines
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= S_IDLE;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_valid_out <= 1'b0;
            o_data_out  <= '0;
            o_eol_out   <= 1'b0;
            o_sof_out   <= 1'b0;
            o_eof_out   <= 1'b0;
            col         <= '0;
            line        <= '0;
            hb_cnt      <= '0;
        end else begin
            o_valid_out <= 1'b0;
            o_eol_out   <= 1'b0;
            o_sof_out   <= 1'b0;
            o_eof_out   <= 1'b0;
            o_done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_start) begin
                        state  <= S_ACTIVE;
                        o_busy <= 1'b1;
                        col    <= '0;
                        line   <= '0;
                    end
                end
                S_ACTIVE: begin
                    if (pop) begin
                        o_valid_out <= 1'b1;
                        o_data_out  <= fifo_mem[rd_ptr];
                        o_sof_out   <= (col == '0) && (line == '0);
                        if (col == LAST_COL) begin
                            o_eol_out <= 1'b1;
                            o_eof_out <= (line == LAST_LINE);
                            col       <= '0;
                            if (line == LAST_LINE) begin
                                state <= S_DONE;
                            end else begin
                                line <= line + LINE_W'(1);
                                if (HBLANK > 0) begin
                                    state  <= S_HBLANK;
                                    hb_cnt <= '0;
                                end
                            end
                        end else begin
                            col <= col + COL_W'(1);
                        end
                    end
                end
                S_HBLANK: begin
                    if (hb_cnt == HB_LAST) begin
                        state <= S_ACTIVE;
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                S_DONE: begin
                    o_done <= 1'b1;
                    o_busy <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_video_frame_source.sv
// tb_video_frame_source
// Directed bench: a 4x3 frame (HBLANK=2, FIFO_DEPTH=4) is read from a memory
// model whose data equals its address, with selectable read latency. A second
// instance with HBLANK=0 checks back-to-back lines.
module tb_video_frame_source;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start0;
    logic       busy, done, rd_en, rd_valid, valid, eol, sof, eof;
    logic [3:0] rd_addr;
    logic [7:0] rd_data, data;
    logic       busy0, done0, rd_en0, rd_valid0, valid0, eol0, sof0, eof0;
    logic [3:0] rd_addr0;
    logic [7:0] rd_data0, data0;

    video_frame_source #(.DATA_WIDTH(8), .LINE_WIDTH(4), .NUM_LINES(3), .HBLANK(2), .FIFO_DEPTH(4)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .o_rd_en(rd_en), .o_rd_addr(rd_addr), .i_rd_valid(rd_valid), .i_rd_data(rd_data),
        .o_valid_out(valid), .o_data_out(data), .o_eol_out(eol), .o_sof_out(sof), .o_eof_out(eof));

    video_frame_source #(.DATA_WIDTH(8), .LINE_WIDTH(4), .NUM_LINES(3), .HBLANK(0), .FIFO_DEPTH(4)) dut0 (
        .i_clk(clk), .i_rst(rst), .i_start(start0), .o_busy(busy0), .o_done(done0),
        .o_rd_en(rd_en0), .o_rd_addr(rd_addr0), .i_rd_valid(rd_valid0), .i_rd_data(rd_data0),
        .o_valid_out(valid0), .o_data_out(data0), .o_eol_out(eol0), .o_sof_out(sof0), .o_eof_out(eof0));

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // memory model and stream recorder state
    int         lat = 1;
    logic       spurious = 1'b0;
    logic       rec_clear = 1'b0;
    logic       pv [8];
    logic [3:0] pa [8];
    logic       q_v0 = 1'b0;
    logic [7:0] q_d0 = 8'h00;
    int         cyc = 0;
    int         beat_n = 0, issued = 0, max_infl = 0, done_n = 0, done_cyc = 0, bad_marker = 0;
    logic [7:0] b_data [32];
    logic       b_eol [32], b_sof [32], b_eof [32];
    int         b_cyc [32];
    logic [3:0] req_addr [32];
    int         beat0_n = 0, done0_n = 0;
    logic [7:0] b0_data [32];
    logic       b0_eol [32];
    int         b0_cyc [32];

    initial begin
        for (int i = 0; i < 8; i++) begin
            pv[i] = 1'b0;
            pa[i] = 4'h0;
        end
        rd_valid  = 1'b0;
        rd_data   = 8'h00;
        rd_valid0 = 1'b0;
        rd_data0  = 8'h00;
    end

    // Memory models (data = address) and output recorders, evaluated mid-cycle
    always @(negedge clk) begin
        cyc++;
        for (int i = 7; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = rd_en && !rst;
        pa[0] = rd_addr;
        if (rst) begin
            for (int i = 0; i < 8; i++) pv[i] = 1'b0;
        end
        rd_valid = pv[lat] | spurious;
        rd_data  = spurious ? 8'hAA : {4'h0, pa[lat]};

        rd_valid0 = q_v0;
        rd_data0  = q_d0;
        q_v0      = rd_en0 && !rst;
        q_d0      = {4'h0, rd_addr0};

        if (rec_clear) begin
            beat_n = 0; issued = 0; max_infl = 0;
            done_n = 0; done_cyc = 0; bad_marker = 0;
        end else begin
            if (valid) begin
                if (beat_n < 32) begin
                    b_data[beat_n] = data;
                    b_eol[beat_n]  = eol;
                    b_sof[beat_n]  = sof;
                    b_eof[beat_n]  = eof;
                    b_cyc[beat_n]  = cyc;
                end
                beat_n++;
            end
            if (rd_en) begin
                if (issued < 32) req_addr[issued] = rd_addr;
                if (issued - beat_n + 1 > max_infl) max_infl = issued - beat_n + 1;
                issued++;
            end
            if (done) begin
                done_n++;
                done_cyc = cyc;
            end
            if (!valid && (eol || sof || eof)) bad_marker++;
        end

        if (valid0) begin
            if (beat0_n < 32) begin
                b0_data[beat0_n] = data0;
                b0_eol[beat0_n]  = eol0;
                b0_cyc[beat0_n]  = cyc;
            end
            beat0_n++;
        end
        if (done0) done0_n++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input bit sel);
        if (sel) start0 = 1'b1; else start = 1'b1;
        waitCycle();
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    task automatic clearRec();
        rec_clear = 1'b1;
        waitCycle();
        rec_clear = 1'b0;
    endtask

    task automatic waitBeats(input int n);
        int k = 0;
        while (beat_n < n && k < 500) begin
            waitCycle();
            k++;
        end
        checkOutput("beat_timeout", 32'(beat_n >= n), 32'd1);
    endtask

    task automatic waitDone();
        int k = 0;
        while (done_n == 0 && k < 500) begin
            waitCycle();
            k++;
        end
        checkOutput("done_timeout", 32'(done_n != 0), 32'd1);
        repeat (4) waitCycle();
    endtask

    task automatic checkFrame();
        logic [7:0] exp_d;
        checkOutput("beat_count", beat_n, 12);
        for (int i = 0; i < 12; i++) begin
            exp_d = 8'(i);
            checkOutput($sformatf("beat%0d_data_eol_sof_eof", i),
                        {21'd0, b_data[i], b_eol[i], b_sof[i], b_eof[i]},
                        {21'd0, exp_d, (i % 4) == 3, i == 0, i == 11});
        end
        checkOutput("done_count", done_n, 1);
        checkOutput("done_after_eof", done_cyc, b_cyc[11] + 1);
        checkOutput("stray_markers", bad_marker, 0);
        checkOutput("busy_after_frame", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        start0 = 1'b0;
        repeat (3) waitCycle();
        checkOutput("reset_outputs", {22'd0, busy, done, rd_en, valid, eol, sof, eof, 3'd0},
                    32'd0);
        checkOutput("reset_data", {24'd0, data}, 32'd0);
        rst = 1'b0;
        waitCycle();

        // 1: single-cycle memory, HBLANK gaps of exactly two idle cycles
        $display("[TB] test 1: 1-cycle memory");
        lat = 1;
        clearRec();
        applyStimulus(1'b0);
        checkOutput("busy_after_start", {31'd0, busy}, 32'd1);
        waitDone();
        checkFrame();
        checkOutput("hblank_gap_line0", b_cyc[4] - b_cyc[3], 3);
        checkOutput("hblank_gap_line1", b_cyc[8] - b_cyc[7], 3);
        checkOutput("first_req_addr", {28'd0, req_addr[0]}, 32'd0);

        // 2: slow memory, credit limit bounds in-flight plus buffered pixels
        $display("[TB] test 2: 6-cycle memory");
        lat = 6;
        clearRec();
        applyStimulus(1'b0);
        waitDone();
        checkFrame();
        checkOutput("credit_limit", 32'(max_infl <= 4), 32'd1);
        checkOutput("output_has_gaps", 32'((b_cyc[11] - b_cyc[0]) > 15), 32'd1);

        // 3: HBLANK=0 instance, lines run back to back
        $display("[TB] test 3: no hblank");
        applyStimulus(1'b1);
        begin
            int k = 0;
            while (done0_n == 0 && k < 500) begin
                waitCycle();
                k++;
            end
        end
        repeat (4) waitCycle();
        checkOutput("nohb_beat_count", beat0_n, 12);
        checkOutput("nohb_done_count", done0_n, 1);
        for (int i = 0; i < 12; i++) begin
            checkOutput($sformatf("nohb_beat%0d_data_eol", i), {23'd0, b0_data[i], b0_eol[i]},
                        {23'd0, 8'(i), (i % 4) == 3});
        end
        checkOutput("nohb_line_boundary", b0_cyc[4] - b0_cyc[3], 1);
        checkOutput("nohb_span", b0_cyc[11] - b0_cyc[0], 11);

        // 4: start re-pulsed mid-frame is ignored
        $display("[TB] test 4: start while busy");
        lat = 1;
        clearRec();
        applyStimulus(1'b0);
        waitBeats(5);
        applyStimulus(1'b0);
        waitDone();
        repeat (10) waitCycle();
        checkFrame();

        // 5: reset mid-frame, then a clean restart from address 0
        $display("[TB] test 5: reset mid-frame");
        clearRec();
        applyStimulus(1'b0);
        waitBeats(6);
        rst = 1'b1;
        waitCycle();
        checkOutput("midreset_outputs", {23'd0, busy, done, rd_en, valid, eol, sof, eof, data[1:0]},
                    32'd0);
        checkOutput("midreset_data", {24'd0, data}, 32'd0);
        waitCycle();
        rst = 1'b0;
        waitCycle();
        clearRec();
        applyStimulus(1'b0);
        waitDone();
        checkFrame();
        checkOutput("restart_addr", {28'd0, req_addr[0]}, 32'd0);

        // 6: spurious read response while idle must not enter the FIFO
        $display("[TB] test 6: spurious rd_valid");
        spurious = 1'b1;
        repeat (3) waitCycle();
        spurious = 1'b0;
        waitCycle();
        clearRec();
        applyStimulus(1'b0);
        waitDone();
        checkFrame();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
